// File: rtl/sat_pkg.sv
// Shared WalkSAT datapath constants and types.
package sat_pkg;

  localparam int unsigned NUM_CLAUSES      = 20;
  localparam int unsigned NUM_CLAUSES_BITS = 5;
  localparam int unsigned NUM_CANDS        = 4;
  localparam int unsigned CAND_BITS        = 2;
  localparam int unsigned POP_CHUNK_W      = 8;

  typedef logic [CAND_BITS-1:0] cand_idx_t;

endpackage

// File: rtl/popcount_chunked.sv
// Combinational popcount split into fixed-width chunks; the top bits of the last chunk are zero-padded.
module popcount_chunked #(
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned CHUNK_W    = 8,
  parameter int unsigned CNT_W      = $clog2(CHUNK_W + 1),
  parameter int unsigned NUM_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W
) (
  input  logic [DATA_W-1:0]           data,
  output logic [NUM_CHUNKS*CNT_W-1:0] counts_c
);

  localparam int unsigned PAD_W = NUM_CHUNKS * CHUNK_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(data);

  always_comb begin
    counts_c = '0;
    for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
      for (int unsigned b = 0; b < CHUNK_W; b++) begin
        counts_c[c*CNT_W +: CNT_W] = counts_c[c*CNT_W +: CNT_W] + CNT_W'(padded[c*CHUNK_W + b]);
      end
    end
  end

endmodule

// File: rtl/break_value_pipe.sv
// Two-stage break value pipeline with per-batch minimum tracking and a held batch result.
module break_value_pipe
  import sat_pkg::POP_CHUNK_W;
#(
  parameter int unsigned NUM_CLAUSES      = sat_pkg::NUM_CLAUSES,
  parameter int unsigned NUM_CLAUSES_BITS = sat_pkg::NUM_CLAUSES_BITS,
  parameter int unsigned NUM_CANDS        = sat_pkg::NUM_CANDS,
  parameter int unsigned CAND_BITS        = sat_pkg::CAND_BITS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        in_last_i,
  input  logic [NUM_CLAUSES-1:0]      clause_broken_i,
  input  logic [NUM_CLAUSES-1:0]      mask_bits_i,
  output logic                        bv_valid_o,
  output logic [NUM_CLAUSES_BITS-1:0] bv_o,
  output logic [CAND_BITS-1:0]        bv_idx_o,
  output logic [NUM_CLAUSES-1:0]      clause_broken_o,
  output logic                        best_valid_o,
  input  logic                        best_ready_i,
  output logic [NUM_CLAUSES_BITS-1:0] best_bv_o,
  output logic [CAND_BITS-1:0]        best_idx_o,
  output logic                        best_zero_o,
  output logic [CAND_BITS:0]          batch_cnt_o,
  output logic                        err_o
);

  localparam int unsigned PCNT_W     = $clog2(POP_CHUNK_W + 1);
  localparam int unsigned NUM_CHUNKS = (NUM_CLAUSES + POP_CHUNK_W - 1) / POP_CHUNK_W;
  localparam int unsigned CNT_W      = CAND_BITS + 1;

  logic                          accept;
  logic                          at_max_idx;
  logic                          last_eff;
  logic                          best_hs;
  logic [CAND_BITS-1:0]          idx_q;
  logic [NUM_CLAUSES-1:0]        masked_c;
  logic [NUM_CHUNKS*PCNT_W-1:0]  partials_c;

  logic                          s1_valid;
  logic                          s1_last;
  logic [CAND_BITS-1:0]          s1_idx;
  logic [NUM_CLAUSES-1:0]        s1_masked;
  logic [NUM_CHUNKS*PCNT_W-1:0]  s1_partials;

  logic [NUM_CLAUSES_BITS-1:0]   bv_sum_c;
  logic                          new_min_c;
  logic [NUM_CLAUSES_BITS-1:0]   best_bv_c;
  logic [CAND_BITS-1:0]          best_idx_c;
  logic [NUM_CLAUSES_BITS-1:0]   min_q;
  logic [CAND_BITS-1:0]          min_idx_q;

  assign accept     = in_valid_i & in_ready_o;
  assign at_max_idx = (idx_q == CAND_BITS'(NUM_CANDS - 1));
  assign last_eff   = in_last_i | at_max_idx;
  assign best_hs    = best_valid_o & best_ready_i;
  assign masked_c   = clause_broken_i & mask_bits_i;

  popcount_chunked #(
    .DATA_W  (NUM_CLAUSES),
    .CHUNK_W (POP_CHUNK_W),
    .CNT_W   (PCNT_W)
  ) u_popcount (
    .data     (masked_c),
    .counts_c (partials_c)
  );

  // Batch index, sticky overflow flag and one-batch-in-flight admission control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      err_o      <= 1'b0;
      in_ready_o <= 1'b1;
    end else begin
      if (best_hs) in_ready_o <= 1'b1;
      if (accept) begin
        idx_q <= last_eff ? '0 : idx_q + CAND_BITS'(1);
        if (at_max_idx && !in_last_i) err_o <= 1'b1;
        if (last_eff) in_ready_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_idx      <= '0;
      s1_masked   <= '0;
      s1_partials <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_last     <= last_eff;
        s1_idx      <= idx_q;
        s1_masked   <= masked_c;
        s1_partials <= partials_c;
      end
    end
  end

  // Stage-2 sum and the minimum as it stands including this beat.
  always_comb begin
    bv_sum_c = '0;
    for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
      bv_sum_c = bv_sum_c + NUM_CLAUSES_BITS'(s1_partials[c*PCNT_W +: PCNT_W]);
    end
    new_min_c  = (s1_idx == '0) || (bv_sum_c < min_q);
    best_bv_c  = new_min_c ? bv_sum_c : min_q;
    best_idx_c = new_min_c ? s1_idx : min_idx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bv_valid_o      <= 1'b0;
      bv_o            <= '0;
      bv_idx_o        <= '0;
      clause_broken_o <= '0;
      min_q           <= '0;
      min_idx_q       <= '0;
      best_valid_o    <= 1'b0;
      best_bv_o       <= '0;
      best_idx_o      <= '0;
      best_zero_o     <= 1'b0;
      batch_cnt_o     <= '0;
    end else begin
      bv_valid_o <= s1_valid;
      if (s1_valid) begin
        bv_o            <= bv_sum_c;
        bv_idx_o        <= s1_idx;
        clause_broken_o <= s1_masked;
        min_q           <= best_bv_c;
        min_idx_q       <= best_idx_c;
      end
      if (s1_valid && s1_last) begin
        best_valid_o <= 1'b1;
        best_bv_o    <= best_bv_c;
        best_idx_o   <= best_idx_c;
        best_zero_o  <= (best_bv_c == '0);
        batch_cnt_o  <= CNT_W'(s1_idx) + CNT_W'(1);
      end else if (best_hs) begin
        best_valid_o <= 1'b0;
      end
    end
  end

endmodule
